// File: rtl/div_sequencer.sv
// Iterative RV32M div/divu/rem/remu unit: radix-2 restoring divider, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow complete directly from accept.
module div_sequencer #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       OP,
  input  logic [XLEN-1:0]  RS1_VAL,
  input  logic [XLEN-1:0]  RS2_VAL,
  input  logic [TAG_W-1:0] IN_TAG,
  input  logic             KILL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  RESULT,
  output logic [TAG_W-1:0] OUT_TAG,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  X_ONE    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  X_ZERO   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  X_ONES   = {XLEN{1'b1}};

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return (~v) + X_ONE;
  endfunction

  state_t             state_q, state_d;
  logic [XLEN-1:0]    quo_q, quo_d;
  logic [XLEN-1:0]    rem_q, rem_d;
  logic [XLEN-1:0]    dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rem_sel_q, rem_sel_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               divz_q, divz_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic               signed_op_s;
  logic               rs1_neg_s;
  logic               rs2_neg_s;
  logic [XLEN-1:0]    abs1_s;
  logic [XLEN-1:0]    abs2_s;
  logic               divz_s;
  logic               accept_s;
  logic [XLEN:0]      rem_sh_s;
  logic [XLEN:0]      trial_s;
  logic [XLEN-1:0]    quo_fix_s;
  logic [XLEN-1:0]    rem_fix_s;
  logic [XLEN-1:0]    fix_result_s;

  assign signed_op_s = ~OP[0];
  assign rs1_neg_s   = signed_op_s & RS1_VAL[XLEN-1];
  assign rs2_neg_s   = signed_op_s & RS2_VAL[XLEN-1];
  assign abs1_s      = rs1_neg_s ? negate(RS1_VAL) : RS1_VAL;
  assign abs2_s      = rs2_neg_s ? negate(RS2_VAL) : RS2_VAL;
  assign divz_s      = (RS2_VAL == X_ZERO);
  assign accept_s    = IN_VALID & (state_q == S_IDLE) & ~KILL;

  // The shifted partial remainder can reach 2*divisor-1, so the trial needs one extra bit.
  assign rem_sh_s = {rem_q, quo_q[XLEN-1]};
  assign trial_s  = rem_sh_s - {1'b0, dvs_q};

  // Quotient sign is dropped for divide-by-zero so the all-ones result survives.
  assign quo_fix_s    = (qneg_q && !divz_q) ? negate(quo_q) : quo_q;
  assign rem_fix_s    = rneg_q ? negate(rem_q) : rem_q;
  assign fix_result_s = rem_sel_q ? rem_fix_s : quo_fix_s;

`ifdef DIV_EARLY_OUT_EN
  logic            ovf_s;
  logic [XLEN-1:0] early_res_s;
  localparam logic [XLEN-1:0] X_MIN = {1'b1, {(XLEN-1){1'b0}}};

  assign ovf_s       = signed_op_s & (RS1_VAL == X_MIN) & (RS2_VAL == X_ONES);
  assign early_res_s = OP[1] ? (divz_s ? RS1_VAL : X_ZERO)
                             : (divz_s ? X_ONES  : RS1_VAL);
`endif

  // Next-state and datapath update for the accept/iterate/fix/handoff sequence.
  always_comb begin
    state_d     = state_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    rem_sel_d   = rem_sel_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    divz_d      = divz_q;
    tag_d       = tag_q;
    result_d    = result_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        out_valid_d = 1'b0;
        if (accept_s) begin
          quo_d     = abs1_s;
          dvs_d     = abs2_s;
          rem_d     = X_ZERO;
          cnt_d     = CNT_LOAD;
          rem_sel_d = OP[1];
          qneg_d    = rs1_neg_s ^ rs2_neg_s;
          rneg_d    = rs1_neg_s;
          divz_d    = divz_s;
          tag_d     = IN_TAG;
`ifdef DIV_EARLY_OUT_EN
          if (divz_s || ovf_s) begin
            result_d    = early_res_s;
            out_tag_d   = IN_TAG;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_CALC;
          end
`else
          state_d = S_CALC;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (KILL) begin
          state_d = S_IDLE;
        end else begin
          quo_d = {quo_q[XLEN-2:0], ~trial_s[XLEN]};
          rem_d = trial_s[XLEN] ? rem_sh_s[XLEN-1:0] : trial_s[XLEN-1:0];
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      S_FIX: begin
        if (KILL) begin
          state_d = S_IDLE;
        end else begin
          result_d    = fix_result_s;
          out_tag_d   = tag_q;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (KILL || OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      quo_q       <= X_ZERO;
      rem_q       <= X_ZERO;
      dvs_q       <= X_ZERO;
      cnt_q       <= {CNT_W{1'b0}};
      rem_sel_q   <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      divz_q      <= 1'b0;
      tag_q       <= {TAG_W{1'b0}};
      result_q    <= X_ZERO;
      out_tag_q   <= {TAG_W{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      rem_sel_q   <= rem_sel_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      divz_q      <= divz_d;
      tag_q       <= tag_d;
      result_q    <= result_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign IN_READY  = ~busy_q;
  assign BUSY      = busy_q;
  assign OUT_VALID = out_valid_q;
  assign RESULT    = result_q;
  assign OUT_TAG   = out_tag_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer (expected latencies follow DIV_EARLY_OUT_EN).
module tb_div_sequencer;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int FULL_LAT = 33;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  in_tag;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_tag;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        sp;
  } vec_t;
  vec_t tbl[$];

  div_sequencer #(.XLEN(32), .TAG_W(5)) dut (
    .CLK(clk), .RSTN(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .OP(op), .RS1_VAL(rs1), .RS2_VAL(rs2), .IN_TAG(in_tag), .KILL(kill),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .RESULT(result),
    .OUT_TAG(out_tag), .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic sp);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.r = r; v.sp = sp;
    tbl.push_back(v);
  endtask

  // Offer one operation; returns 1 time unit after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tg);
    @(negedge clk);
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b; in_tag = tg;
    chk("issue_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, input int lat, input logic [31:0] r,
                          input logic [4:0] tg);
    int  n;
    logic bz_ok;
    n = 0;
    bz_ok = 1'b1;
    while (1) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) bz_ok = 1'b0;
      if (out_valid === 1'b1 || n >= 100) break;
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_lat"}, n, lat);
    chk({nm, "_busy"}, {31'd0, bz_ok}, 32'd1);
    chk({nm, "_res"}, result, r);
    chk({nm, "_tag"}, {27'd0, out_tag}, {27'd0, tg});
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("take_valid", {31'd0, out_valid}, 32'd0);
    chk("take_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic hold_ok;
    rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; rs1 = 32'd0; rs2 = 32'd0;
    in_tag = 5'd0; kill = 1'b0; out_ready = 1'b0;

    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_tag", {27'd0, out_tag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    add(OP_DIV,  32'd100,        32'd7,          32'd14,         1'b0);
    add(OP_REM,  32'd100,        32'd7,          32'd2,          1'b0);
    add(OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0);
    add(OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0);
    add(OP_DIVU, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   1'b0);
    add(OP_REMU, 32'hFFFFFFF9,   32'd2,          32'd1,          1'b0);
    add(OP_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0);
    add(OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          1'b0);
    add(OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         1'b0);
    add(OP_REM,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   1'b0);
    add(OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0);
    add(OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   1'b1);
    add(OP_REM,  32'd5,          32'd0,          32'd5,          1'b1);
    add(OP_DIV,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   1'b1);
    add(OP_REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1'b1);
    add(OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   1'b1);
    add(OP_REMU, 32'd7,          32'd0,          32'd7,          1'b1);
    add(OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1);
    add(OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 1));
      wait_out($sformatf("vec%0d", i), (tbl[i].sp && EARLY == 1) ? 0 : FULL_LAT,
               tbl[i].r, 5'(i + 1));
      take();
    end

    // Writeback back-pressure: output must hold while a new op is being offered.
    issue(OP_DIV, 32'd100, 32'd7, 5'd9);
    wait_out("hold", FULL_LAT, 32'd14, 5'd9);
    @(negedge clk);
    in_valid = 1'b1; op = OP_DIVU; rs1 = 32'd9; rs2 = 32'd3; in_tag = 5'd12;
    hold_ok = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (result !== 32'd14 || out_tag !== 5'd9 || out_valid !== 1'b1 || in_ready !== 1'b0)
        hold_ok = 1'b0;
    end
    chk("hold_stable", {31'd0, hold_ok}, 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("handoff_valid", {31'd0, out_valid}, 32'd0);
    chk("handoff_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("next_accept", {31'd0, busy}, 32'd1);
    wait_out("after_hold", FULL_LAT, 32'd3, 5'd12);
    take();

    // Flush mid-iteration, then issue immediately.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd20);
    repeat (8) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill_busy", {31'd0, busy}, 32'd0);
    chk("kill_valid", {31'd0, out_valid}, 32'd0);
    issue(OP_DIVU, 32'd9, 32'd3, 5'd7);
    wait_out("post_kill", FULL_LAT, 32'd3, 5'd7);
    take();

    // Asynchronous reset mid-operation; RESULT still holds 3 from the previous op.
    issue(OP_DIV, 32'd100, 32'd7, 5'd4);
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", {31'd0, out_valid}, 32'd0);
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk("areset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("areset_ready", {31'd0, in_ready}, 32'd1);
    chk("areset_novalid", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Iterative RV32M divide/remainder unit for the execute stage; sits beside aluer and handles div, divu, rem and remu, which aluer does not implement.
- Accepts one operation through a valid/ready handshake.
- Runs a radix-2 restoring division, one quotient bit per cycle.
- Holds the result until writeback accepts it.
- Decode stalls issue on IN_READY; flush cancels an in-flight operation via KILL.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.
TAG_W, 5, width of the destination-register tag passed through unchanged.

Ports:
CLK  input  1  clock, rising edge.
RSTN  input  1  asynchronous active-low reset.
IN_VALID  input  1  operation offered.
IN_READY  output  1  unit can accept; high only in IDLE.
OP  input  2  00 div, 01 divu, 10 rem, 11 remu.
RS1_VAL  input  XLEN  dividend.
RS2_VAL  input  XLEN  divisor.
IN_TAG  input  TAG_W  destination tag.
KILL  input  1  flush; aborts the current operation.
OUT_VALID  output  1  result available.
OUT_READY  input  1  writeback accepts the result.
RESULT  output  XLEN  quotient or remainder.
OUT_TAG  output  TAG_W  tag captured at accept.
BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (RSTN=0, asynchronous, any state):
  - state=IDLE.
  - OUT_VALID=0, RESULT=0, OUT_TAG=0, BUSY=0, all internal registers 0.
  - IN_READY=1 once reset is deasserted.
  - A reset mid-operation discards that operation with no output.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept when IN_VALID && IN_READY (edge k).
  - Latch OP and IN_TAG.
  - Latch |RS1| and |RS2| (absolute values for signed ops; raw values for divu/remu).
  - Latch sign flags: quotient negative = sign(RS1) XOR sign(RS2); remainder negative = sign(RS1).
  - Clear the remainder register; load the iteration counter with XLEN-1.
  - Go to CALC.
- CALC, one step per cycle:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem - divisor as XLEN+1 bits.
  - If trial is non-negative, rem=trial and quo[0]=1.
  - Counter decrements; after XLEN steps (cycles k+1..k+XLEN), go to FIX.
- FIX, one cycle:
  - Apply two's-complement negation per the sign flags (signed ops only).
  - Select the quotient (div/divu) or remainder (rem/remu) into RESULT; OUT_TAG = latched tag.
  - Go to DONE.
- DONE:
  - OUT_VALID=1 from cycle k+XLEN+2; latency is 34 for XLEN=32.
  - RESULT and OUT_TAG stay stable while OUT_VALID && !OUT_READY.
  - On OUT_READY: OUT_VALID=0 and return to IDLE.
  - The next accept is possible one cycle later; there is no accept in the same cycle as the handoff.
- KILL:
  - In CALC, FIX or DONE: next state IDLE, OUT_VALID=0, no result delivered.
  - KILL takes priority over OUT_READY in the same cycle.
  - In IDLE, KILL blocks an accept in that cycle.
- Divide by zero (RISC-V defined, no trap):
  - div and divu give all ones.
  - rem and remu give RS1.
- Signed overflow (RS1=0x80000000, RS2=0xFFFFFFFF):
  - div gives 0x80000000.
  - rem gives 0.
- Both special cases fall out of the normal datapath once FIX suppresses negation:
  - divide by zero: suppress negation of the quotient;
  - overflow: |0x80000000| is handled as an XLEN-bit unsigned value.
- Width: all arithmetic is unsigned XLEN bits. Sign is applied only in FIX. The trial subtraction uses XLEN+1 bits.

Optional Feature:
DIV_EARLY_OUT_EN:
- Defined: at accept, the divide-by-zero and signed-overflow cases skip CALC and FIX.
  - Load the architectural result directly and enter DONE; OUT_VALID is high at cycle k+1.
  - All other operations keep the full XLEN+2 latency.
- Undefined: every operation takes XLEN+2 cycles and produces identical results.

Test Plan:
1. div 100/7, tag 3 -> OUT_VALID at k+34, RESULT=14, OUT_TAG=3; rem 100/7 -> 2; IN_READY=0 and BUSY=1 during k+1..k+34.
2. div -7/2 -> 0xFFFFFFFD (-3); rem -7/2 -> 0xFFFFFFFF (-1); divu 0xFFFFFFF9/2 -> 0x7FFFFFFC; remu 0xFFFFFFF9/2 -> 1.
3. div 5/0 -> 0xFFFFFFFF; rem 5/0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000, rem -> 0. Latency is k+1 with DIV_EARLY_OUT_EN defined, k+34 without.
4. Hold OUT_READY=0 for 10 cycles after OUT_VALID -> RESULT and OUT_TAG stable, no new accept; raise OUT_READY -> IDLE next cycle; the next IN_VALID is accepted one cycle later.
5. KILL at k+10, then immediately issue divu 9/3 -> the killed op never shows OUT_VALID; the new op gives 3 at its own k+34.
6. Assert RSTN low at k+20, asynchronously mid-cycle -> OUT_VALID=0, BUSY=0, RESULT=0 immediately; IN_READY=1 after release.
